// File: rtl/boot_loader.sv
// Boot loader: receives a length-prefixed little-endian program image over a
// byte-wide valid/ready link, writes it word by word into the instruction/data
// RAM while holding the cpu in reset, then releases the cpu and hands the
// memory port over to it. A reload pulse in RUN starts a fresh load.
module boot_loader #(
    parameter int AWIDTH    = 16,
    parameter int DWIDTH    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              cpu_rst,
    output logic              done,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [AWIDTH-2:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [AWIDTH-2:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata
);

    localparam int AW = AWIDTH - 1;

    localparam logic [2:0] S_LEN_LO = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_DAT_LO = 3'd2;
    localparam logic [2:0] S_DAT_HI = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;

    localparam logic [AW-1:0] BASE_W = AW'(BASE_ADDR);

    logic [2:0]        state_r;
    logic [7:0]        lo_r;        // holds LEN_LO or a word's LO byte
    logic [15:0]       len_r;
    logic [15:0]       count_r;     // words written in this image
    logic              ld_we_r;
    logic [AW-1:0]     ld_addr_r;
    logic [DWIDTH-1:0] ld_wdata_r;
    logic              in_ready_r;
    logic              cpu_rst_r;
    logic              done_r;

    logic              xfer;
    logic [15:0]       hi_lo;
    logic [AW-1:0]     addr_next;
    logic              sel_cpu;

    assign xfer      = in_valid & in_ready_r;
    assign hi_lo     = {in_data, lo_r};
    // Word address wraps modulo the memory size.
    assign addr_next = BASE_W + AW'(count_r);

    // The final loader write is still on the bus during the first RUN cycle,
    // so the cpu only takes over the port once that write has gone out.
    assign sel_cpu   = (state_r == S_RUN) && !ld_we_r;

    assign in_ready  = in_ready_r;
    assign cpu_rst   = cpu_rst_r;
    assign done      = done_r;

    // Load sequencer: byte parsing, word assembly, write issue and cpu release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_LEN_LO;
            lo_r       <= 8'h00;
            len_r      <= 16'h0000;
            count_r    <= 16'h0000;
            ld_we_r    <= 1'b0;
            ld_addr_r  <= BASE_W;
            ld_wdata_r <= '0;
            in_ready_r <= 1'b0;
            cpu_rst_r  <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            ld_we_r <= 1'b0;
            case (state_r)
                S_LEN_LO: begin
                    in_ready_r <= 1'b1;
                    if (xfer) begin
                        lo_r    <= in_data;
                        state_r <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    in_ready_r <= 1'b1;
                    if (xfer) begin
                        len_r <= hi_lo;
                        if (hi_lo == 16'h0000) begin
                            state_r    <= S_RUN;
                            in_ready_r <= 1'b0;
                            cpu_rst_r  <= 1'b0;
                            done_r     <= 1'b1;
                        end else begin
                            state_r <= S_DAT_LO;
                        end
                    end
                end
                S_DAT_LO: begin
                    in_ready_r <= 1'b1;
                    if (xfer) begin
                        lo_r    <= in_data;
                        state_r <= S_DAT_HI;
                    end
                end
                S_DAT_HI: begin
                    in_ready_r <= 1'b1;
                    if (xfer) begin
                        ld_we_r    <= 1'b1;
                        ld_addr_r  <= addr_next;
                        ld_wdata_r <= DWIDTH'(hi_lo);
                        count_r    <= count_r + 16'd1;
                        if (count_r == len_r - 16'd1) begin
                            state_r    <= S_RUN;
                            in_ready_r <= 1'b0;
                            cpu_rst_r  <= 1'b0;
                            done_r     <= 1'b1;
                        end else begin
                            state_r <= S_DAT_LO;
                        end
                    end
                end
                S_RUN: begin
                    in_ready_r <= reload;
                    if (reload) begin
                        state_r   <= S_LEN_LO;
                        cpu_rst_r <= 1'b1;
                        done_r    <= 1'b0;
                        count_r   <= 16'h0000;
                        ld_addr_r <= BASE_W;
                    end
                end
                default: begin
                    state_r    <= S_LEN_LO;
                    in_ready_r <= 1'b0;
                    cpu_rst_r  <= 1'b1;
                    done_r     <= 1'b0;
                    count_r    <= 16'h0000;
                end
            endcase
        end
    end

    // Memory port mux: cpu passthrough in RUN, loader registers otherwise.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = ld_addr_r;
        mem_wdata = ld_wdata_r;
        if (sel_cpu) begin
            mem_re    = cpu_re;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else begin
            mem_re    = 1'b0;
            mem_we    = ld_we_r;
            mem_addr  = ld_addr_r;
            mem_wdata = ld_wdata_r;
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: a directed vector table, hand-written multi-cycle
// sequences, and a randomized phase checked against a stream-level model.
// Two instances share all inputs: one with BASE_ADDR=0, one with 0x7FFF.
module tb_boot_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        reload;
    logic        cpu_re;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_wdata;

    logic        a_in_ready, a_cpu_rst, a_done, a_mem_re, a_mem_we;
    logic [14:0] a_mem_addr;
    logic [15:0] a_mem_wdata;
    logic        b_in_ready, b_cpu_rst, b_done, b_mem_re, b_mem_we;
    logic [14:0] b_mem_addr;
    logic [15:0] b_mem_wdata;

    boot_loader #(.AWIDTH(16), .DWIDTH(16), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_in_ready), .reload(reload), .cpu_rst(a_cpu_rst), .done(a_done),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .mem_re(a_mem_re), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata)
    );

    boot_loader #(.AWIDTH(16), .DWIDTH(16), .BASE_ADDR(32'h7FFF)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .reload(reload), .cpu_rst(b_cpu_rst), .done(b_done),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- stream-level reference model ----------------
    bit          m_loading;   // image not yet complete: cpu held in reset
    bit          m_rdy;       // loader advertises ready this cycle
    bit          m_wr;        // a word write is on the bus this cycle
    int          m_nbytes;    // bytes accepted in the current image
    int          m_len;
    int          m_wr_idx;
    logic [7:0]  m_lo;
    logic [15:0] m_wr_data;
    int          a_we_seen;

    function automatic void model_reset();
        m_loading = 1'b1;
        m_rdy     = 1'b0;
        m_wr      = 1'b0;
        m_nbytes  = 0;
        m_len     = 0;
    endfunction

    function automatic void model_update();
        m_wr = 1'b0;
        if (m_loading) begin
            if (in_valid && m_rdy) begin
                if (m_nbytes == 0) m_lo = in_data;
                else if (m_nbytes == 1) m_len = int'({in_data, m_lo});
                else if (m_nbytes % 2 == 0) m_lo = in_data;
                else begin
                    m_wr      = 1'b1;
                    m_wr_idx  = (m_nbytes - 3) / 2;
                    m_wr_data = {in_data, m_lo};
                end
                m_nbytes++;
                if (m_nbytes >= 2 && m_nbytes == 2 + 2 * m_len) m_loading = 1'b0;
            end
        end else if (reload) begin
            m_loading = 1'b1;
            m_nbytes  = 0;
        end
        m_rdy = m_loading;
    endfunction

    task automatic check_dut(input string t, input int base, input logic rdy, input logic crst,
                             input logic dn, input logic we, input logic re,
                             input logic [14:0] addr, input logic [15:0] wd);
        chk({t, ".in_ready"}, 32'(rdy), 32'(m_rdy));
        chk({t, ".cpu_rst"},  32'(crst), 32'(m_loading));
        chk({t, ".done"},     32'(dn), 32'(!m_loading));
        if (m_wr) begin
            chk({t, ".wr_we"},    32'(we), 32'd1);
            chk({t, ".wr_re"},    32'(re), 32'd0);
            chk({t, ".wr_addr"},  32'(addr), 32'((base + m_wr_idx) % 32768));
            chk({t, ".wr_data"},  32'(wd), 32'(m_wr_data));
        end else if (!m_loading) begin
            chk({t, ".run_we"},   32'(we), 32'(cpu_we));
            chk({t, ".run_re"},   32'(re), 32'(cpu_re));
            chk({t, ".run_addr"}, 32'(addr), 32'(cpu_addr));
            chk({t, ".run_data"}, 32'(wd), 32'(cpu_wdata));
        end else begin
            chk({t, ".load_we"},  32'(we), 32'd0);
            chk({t, ".load_re"},  32'(re), 32'd0);
        end
    endtask

    // One clock: model follows the edge, both instances checked mid-cycle.
    task automatic step();
        @(posedge clk);
        if (rst) model_update();
        else model_reset();
        @(negedge clk);
        if (a_mem_we) a_we_seen++;
        check_dut("a", 0, a_in_ready, a_cpu_rst, a_done, a_mem_we, a_mem_re, a_mem_addr, a_mem_wdata);
        check_dut("b", 32'h7FFF, b_in_ready, b_cpu_rst, b_done, b_mem_we, b_mem_re, b_mem_addr, b_mem_wdata);
    endtask

    // Asynchronous reset: outputs must take reset values without a clock.
    task automatic do_reset(input string t);
        rst = 1'b0;
        in_valid = 1'b0;
        reload = 1'b0;
        #1;
        model_reset();
        chk({t, ".rst_we_a"},    32'(a_mem_we), 32'd0);
        chk({t, ".rst_we_b"},    32'(b_mem_we), 32'd0);
        chk({t, ".rst_re_a"},    32'(a_mem_re), 32'd0);
        chk({t, ".rst_cpu_rst"}, 32'(a_cpu_rst), 32'd1);
        chk({t, ".rst_done"},    32'(a_done), 32'd0);
        chk({t, ".rst_ready"},   32'(a_in_ready), 32'd0);
        chk({t, ".rst_addr_a"},  32'(a_mem_addr), 32'h0);
        chk({t, ".rst_addr_b"},  32'(b_mem_addr), 32'h7FFF);
        chk({t, ".rst_wdata"},   32'(a_mem_wdata), 32'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Offer a byte until the loader takes it (bounded).
    task automatic send_byte(input logic [7:0] b);
        bit took;
        in_data  = b;
        in_valid = 1'b1;
        took = 1'b0;
        for (int k = 0; k < 4 && !took; k++) begin
            took = m_rdy;
            step();
        end
        if (!took) begin
            failures++;
            $display("FAIL send_byte timeout actual=not_taken expected=taken");
        end
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic        rst_v, vld;
        logic [7:0]  d;
        logic        rl, cre, cwe;
        logic [14:0] caddr;
        logic        e_rdy, e_crst, e_done, e_we, e_re, chk_bus;
        logic [14:0] e_addr;
        logic [15:0] e_wd;
    } vec_t;

    vec_t tv[15];
    logic [7:0] q[$];

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
        cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = 15'h0; cpu_wdata = 16'hBEEF;
        a_we_seen = 0;
        model_reset();

        //        rst vld data  rl cre cwe caddr     rdy crst done we re bus addr     wdata
        tv[0]  = '{0, 0, 8'h00, 0, 0, 0, 15'h0000, 0, 1, 0, 0, 0, 1, 15'h0000, 16'h0000};
        tv[1]  = '{1, 1, 8'h02, 0, 0, 0, 15'h0000, 1, 1, 0, 0, 0, 0, 15'h0000, 16'h0000};
        tv[2]  = '{1, 1, 8'h02, 0, 0, 0, 15'h0000, 1, 1, 0, 0, 0, 0, 15'h0000, 16'h0000};
        tv[3]  = '{1, 1, 8'h00, 0, 0, 0, 15'h0000, 1, 1, 0, 0, 0, 0, 15'h0000, 16'h0000};
        tv[4]  = '{1, 1, 8'h34, 0, 0, 0, 15'h0000, 1, 1, 0, 0, 0, 0, 15'h0000, 16'h0000};
        tv[5]  = '{1, 1, 8'h12, 0, 0, 0, 15'h0000, 1, 1, 0, 1, 0, 1, 15'h0000, 16'h1234};
        tv[6]  = '{1, 1, 8'h78, 0, 0, 0, 15'h0000, 1, 1, 0, 0, 0, 0, 15'h0000, 16'h0000};
        tv[7]  = '{1, 1, 8'h56, 0, 1, 0, 15'h0005, 0, 0, 1, 1, 0, 1, 15'h0001, 16'h5678};
        tv[8]  = '{1, 0, 8'h00, 0, 1, 0, 15'h0005, 0, 0, 1, 0, 1, 1, 15'h0005, 16'hBEEF};
        tv[9]  = '{1, 0, 8'h00, 1, 1, 0, 15'h0005, 1, 1, 0, 0, 0, 0, 15'h0000, 16'h0000};
        tv[10] = '{1, 1, 8'h00, 0, 0, 0, 15'h0000, 1, 1, 0, 0, 0, 0, 15'h0000, 16'h0000};
        tv[11] = '{1, 1, 8'h00, 0, 0, 0, 15'h0123, 0, 0, 1, 0, 0, 1, 15'h0123, 16'hBEEF};
        tv[12] = '{1, 1, 8'h55, 0, 0, 1, 15'h0123, 0, 0, 1, 1, 0, 1, 15'h0123, 16'hBEEF};
        tv[13] = '{1, 1, 8'h01, 1, 0, 0, 15'h0000, 1, 1, 0, 0, 0, 0, 15'h0000, 16'h0000};
        tv[14] = '{1, 1, 8'h01, 0, 0, 0, 15'h0000, 1, 1, 0, 0, 0, 0, 15'h0000, 16'h0000};

        for (int i = 0; i < 15; i++) begin
            rst = tv[i].rst_v; in_valid = tv[i].vld; in_data = tv[i].d; reload = tv[i].rl;
            cpu_re = tv[i].cre; cpu_we = tv[i].cwe; cpu_addr = tv[i].caddr;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d.in_ready", i), 32'(a_in_ready), 32'(tv[i].e_rdy));
            chk($sformatf("vec%0d.cpu_rst", i),  32'(a_cpu_rst),  32'(tv[i].e_crst));
            chk($sformatf("vec%0d.done", i),     32'(a_done),     32'(tv[i].e_done));
            chk($sformatf("vec%0d.mem_we", i),   32'(a_mem_we),   32'(tv[i].e_we));
            chk($sformatf("vec%0d.mem_re", i),   32'(a_mem_re),   32'(tv[i].e_re));
            if (tv[i].chk_bus) begin
                chk($sformatf("vec%0d.mem_addr", i),  32'(a_mem_addr),  32'(tv[i].e_addr));
                chk($sformatf("vec%0d.mem_wdata", i), 32'(a_mem_wdata), 32'(tv[i].e_wd));
            end
        end
        in_valid = 1'b0; reload = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0;

        // Wrap: instance b writes at 0x7FFF then 0x0000.
        do_reset("t4");
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        chk("t4.first_addr", 32'(b_mem_addr), 32'h7FFF);
        send_byte(8'h33); send_byte(8'h44);
        chk("t4.wrap_addr", 32'(b_mem_addr), 32'h0000);
        chk("t4.wrap_data", 32'(b_mem_wdata), 32'h4433);
        step();

        // Host stalls every other cycle during a 3-word load.
        do_reset("t5");
        step();
        send_byte(8'h03); send_byte(8'h00);
        a_we_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            send_byte(8'hA0 + 8'(i));
        end
        step(); step();
        chk("t5.write_count", 32'(a_we_seen), 32'd3);

        // Reset mid-load after LEN and one data byte, and during a write cycle.
        do_reset("t6a");
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hCD);
        do_reset("t6b");
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        chk("t6.pre_we", 32'(a_mem_we), 32'd1);
        do_reset("t6c");
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hCD); send_byte(8'hAB);
        chk("t6.fresh_data", 32'(a_mem_wdata), 32'hABCD);
        chk("t6.fresh_addr_a", 32'(a_mem_addr), 32'h0000);
        chk("t6.fresh_addr_b", 32'(b_mem_addr), 32'h7FFF);
        chk("t6.fresh_done", 32'(a_done), 32'd1);
        step();

        // Randomized phase: random images, stalls, reloads and cpu traffic.
        q.delete();
        for (int c = 0; c < 6000; c++) begin
            bit took;
            if (m_loading && q.size() == 0) begin
                int len;
                len = $urandom_range(0, 5);
                if ($urandom_range(0, 9) == 0) len = $urandom_range(250, 300);
                q.push_back(8'(len));
                q.push_back(8'(len >> 8));
                for (int k = 0; k < 2 * len; k++) q.push_back(8'($urandom));
            end
            in_valid  = (q.size() > 0) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
            in_data   = (q.size() > 0) ? q[0] : 8'($urandom);
            reload    = ($urandom_range(0, 15) == 0);
            cpu_re    = 1'($urandom);
            cpu_we    = 1'($urandom);
            cpu_addr  = 15'($urandom);
            cpu_wdata = 16'($urandom);
            took = in_valid && m_rdy && (q.size() > 0);
            step();
            if (took) void'(q.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
